// File: rtl/rv_pkg.sv
// Shared types for the instruction-fetch queue: queued entry layout and FSM states.
package rv_pkg;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_IDLE,
    FQ_WAIT,
    FQ_DROP
  } fq_state_t;

  localparam int unsigned FQ_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with clear, occupancy count and a registered head entry.
// Simultaneous push and pop are allowed, including when full.
module rv_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear && !i_reset) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/rv_fetch_queue.sv
// Fetch front end: one-outstanding req/ack bus master feeding a decode queue.
// Optional feature macro RV_FETCH_BYPASS_EN gives a zero-latency path for words arriving at an empty queue.
module rv_fetch_queue
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEFAULT_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [29:0] i_pc,
  input  logic        i_flush,
  output logic        o_pc_adv,
  output logic        o_bus_req,
  output logic [29:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [29:0] o_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fq_state_t      state_q, state_d;
  logic [29:0]    addr_q, addr_d;

  fetch_entry_t   push_entry, head_entry;
  logic [CW-1:0]  fifo_count, count_after;
  logic           fifo_full, fifo_empty;
  logic           ack_ok, push, pop;

  assign ack_ok = (state_q == FQ_WAIT) && i_bus_ack && !i_flush && !i_reset;
  assign pop    = !fifo_empty && i_ready;

  assign push_entry.pc    = addr_q;
  assign push_entry.instr = i_bus_rdata;

`ifdef RV_FETCH_BYPASS_EN
  logic bypass;
  assign bypass  = ack_ok && fifo_empty;
  assign push    = ack_ok && !(bypass && i_ready);
  assign o_valid = !fifo_empty || bypass;
  assign o_instr = fifo_empty ? i_bus_rdata : head_entry.instr;
  assign o_pc    = fifo_empty ? addr_q      : head_entry.pc;
`else
  assign push    = ack_ok;
  assign o_valid = !fifo_empty;
  assign o_instr = head_entry.instr;
  assign o_pc    = head_entry.pc;
`endif

  assign count_after = fifo_count + CW'(push) - CW'(pop);

  rv_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_push  (push),
    .i_data  (push_entry),
    .i_pop   (pop),
    .o_head  (head_entry),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= FQ_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Keep requesting back-to-back only while the queue can still absorb the next word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      FQ_IDLE: begin
        if (!i_flush && !fifo_full) begin
          addr_d  = i_pc;
          state_d = FQ_WAIT;
        end
      end
      FQ_WAIT: begin
        if (i_flush) begin
          state_d = i_bus_ack ? FQ_IDLE : FQ_DROP;
        end else if (i_bus_ack) begin
          if (count_after < CW'(DEPTH)) addr_d = addr_q + 30'd1;
          else                          state_d = FQ_IDLE;
        end
      end
      FQ_DROP: begin
        if (i_bus_ack) state_d = FQ_IDLE;
      end
      default: state_d = FQ_IDLE;
    endcase
  end

  assign o_bus_req  = (state_q != FQ_IDLE);
  assign o_bus_addr = addr_q;
  assign o_pc_adv   = ack_ok;

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue against a queue-based fetch/decode reference model.
// Honours RV_FETCH_BYPASS_EN when compiled with it.
module tb_rv_fetch_queue;

  localparam int DEPTH = 4;
`ifdef RV_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [29:0] i_pc = '0;
  logic        i_flush = 1'b0;
  logic        o_pc_adv;
  logic        o_bus_req;
  logic [29:0] o_bus_addr;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [29:0] o_pc;

  always #5 i_clk = ~i_clk;

  rv_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_pc        (i_pc),
    .i_flush     (i_flush),
    .o_pc_adv    (o_pc_adv),
    .o_bus_req   (o_bus_req),
    .o_bus_addr  (o_bus_addr),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_instr     (o_instr),
    .o_pc        (o_pc)
  );

  typedef struct {
    logic [29:0] pc;
    logic [31:0] instr;
  } ent_t;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: decode-visible queue, fetch PC, and the bus transaction view.
  ent_t        mq[$];
  bit          out = 1'b0;
  bit          dropping = 1'b0;
  logic [29:0] fpc = '0;

  bit          rstS = 1'b0, flushS = 1'b0, ackS = 1'b0, readyS = 1'b0;
  bit          useFixed = 1'b0;
  logic [31:0] fixedData = '0;
  logic [29:0] tgtS = '0;

  int          accCount = 0;
  logic [29:0] accAddrs[$];
  logic        sValid;
  logic [31:0] sInstr;

  // One clock cycle: drive at the falling edge, check comb outputs, advance the model.
  task automatic step();
    logic [31:0] rdata;
    bit ack, accept, byp, expValid;
    int sz;
    ent_t hd;
    rdata = useFixed ? fixedData : $urandom;
    ack = ackS && out;
    i_reset = rstS; i_flush = flushS; i_bus_ack = ack;
    i_bus_rdata = rdata; i_ready = readyS; i_pc = fpc;
    #1;
    sValid = o_valid;
    sInstr = o_instr;
    if (rstS) begin
      nChecks++;
      if (o_pc_adv !== 1'b0) begin nFails++; $display("[TB] FAIL pc_adv_in_reset: got %b expected 0", o_pc_adv); end
      mq.delete(); out = 1'b0; dropping = 1'b0;
    end else begin
      accept   = out && ack && !dropping && !flushS;
      sz       = mq.size();
      byp      = BYP && accept && (sz == 0);
      expValid = (sz > 0) || byp;
      nChecks++;
      if (o_bus_req !== out) begin nFails++; $display("[TB] FAIL bus_req: got %b expected %b", o_bus_req, out); end
      nChecks++;
      if (o_pc_adv !== accept) begin nFails++; $display("[TB] FAIL pc_adv: got %b expected %b", o_pc_adv, accept); end
      nChecks++;
      if (o_valid !== expValid) begin nFails++; $display("[TB] FAIL valid: got %b expected %b", o_valid, expValid); end
      if (accept) begin
        nChecks++;
        if (o_bus_addr !== fpc) begin nFails++; $display("[TB] FAIL bus_addr: got %h expected %h", o_bus_addr, fpc); end
        accAddrs.push_back(o_bus_addr);
        accCount++;
      end
      if (expValid && readyS) begin
        hd = (sz > 0) ? mq[0] : ent_t'{fpc, rdata};
        nChecks++;
        if (o_pc !== hd.pc) begin nFails++; $display("[TB] FAIL head_pc: got %h expected %h", o_pc, hd.pc); end
        nChecks++;
        if (o_instr !== hd.instr) begin nFails++; $display("[TB] FAIL head_instr: got %h expected %h", o_instr, hd.instr); end
      end
      if (flushS) begin
        mq.delete();
        if (out) begin
          if (ack) begin out = 1'b0; dropping = 1'b0; end
          else dropping = 1'b1;
        end
        fpc = tgtS;
      end else begin
        if (expValid && readyS && sz > 0) void'(mq.pop_front());
        if (accept && !(byp && readyS)) mq.push_back(ent_t'{fpc, rdata});
        if (dropping && ack) begin
          dropping = 1'b0; out = 1'b0;
        end else if (accept) begin
          out = (mq.size() < DEPTH);
          fpc = fpc + 30'd1;
        end else if (!out && sz < DEPTH) begin
          out = 1'b1;
        end
      end
    end
    @(negedge i_clk);
  endtask

  task automatic doReset();
    rstS = 1'b1; flushS = 1'b0; ackS = 1'b0;
    step();
    rstS = 1'b0;
  endtask

  task automatic test_reset();
    rstS = 1'b1;
    step();
    step();
    rstS = 1'b0;
    nChecks++;
    if (o_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
    nChecks++;
    if (o_bus_req !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req: got %b expected 0", o_bus_req); end
    nChecks++;
    if (o_pc_adv !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pc_adv: got %b expected 0", o_pc_adv); end
    nChecks++;
    if (o_bus_addr !== 30'h0) begin nFails++; $display("[TB] FAIL reset_addr: got %h expected 0", o_bus_addr); end
  endtask

  task automatic test_stream();
    int n0;
    fpc = 30'h100; readyS = 1'b1; ackS = 1'b1;
    n0 = accAddrs.size();
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (accAddrs.size() <= n0 + i) begin
        nFails++; $display("[TB] FAIL stream_addr%0d: got none expected %h", i, 30'h100 + i);
      end else if (accAddrs[n0+i] !== 30'h100 + 30'(i)) begin
        nFails++; $display("[TB] FAIL stream_addr%0d: got %h expected %h", i, accAddrs[n0+i], 30'h100 + 30'(i));
      end
    end
  endtask

  task automatic test_full();
    int c0;
    logic [29:0] last;
    doReset();
    readyS = 1'b0; ackS = 1'b1;
    c0 = accCount;
    repeat (12) step();
    nChecks++;
    if (accCount - c0 !== DEPTH) begin nFails++; $display("[TB] FAIL full_accepts: got %0d expected %0d", accCount - c0, DEPTH); end
    nChecks++;
    if (o_bus_req !== 1'b0) begin nFails++; $display("[TB] FAIL full_req_low: got %b expected 0", o_bus_req); end
    last = accAddrs[$];
    readyS = 1'b1;
    step();
    readyS = 1'b0;
    repeat (4) step();
    nChecks++;
    if (accCount - c0 !== DEPTH + 1) begin nFails++; $display("[TB] FAIL refill_accepts: got %0d expected %0d", accCount - c0, DEPTH + 1); end
    nChecks++;
    if (accAddrs[$] !== last + 30'd1) begin nFails++; $display("[TB] FAIL refill_addr: got %h expected %h", accAddrs[$], last + 30'd1); end
  endtask

  task automatic test_flush_drop();
    int n0, c0;
    doReset();
    readyS = 1'b1; ackS = 1'b0; fpc = 30'h180;
    step();
    step();
    flushS = 1'b1; tgtS = 30'h200;
    step();
    flushS = 1'b0;
    c0 = accCount;
    step();
    step();
    ackS = 1'b1;
    step();
    nChecks++;
    if (accCount !== c0) begin nFails++; $display("[TB] FAIL drop_no_accept: got %0d expected %0d", accCount, c0); end
    n0 = accAddrs.size();
    repeat (3) step();
    nChecks++;
    if (accAddrs.size() <= n0) begin
      nFails++; $display("[TB] FAIL drop_new_addr: got none expected 200");
    end else if (accAddrs[n0] !== 30'h200) begin
      nFails++; $display("[TB] FAIL drop_new_addr: got %h expected 200", accAddrs[n0]);
    end
  endtask

  task automatic test_flush_ack();
    doReset();
    readyS = 1'b0; ackS = 1'b1; fpc = 30'h40;
    repeat (3) step();
    flushS = 1'b1; tgtS = 30'h80;
    step();
    flushS = 1'b0; ackS = 1'b0;
    nChecks++;
    if (o_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush_ack_valid: got %b expected 0", o_valid); end
    nChecks++;
    if (o_bus_req !== 1'b0) begin nFails++; $display("[TB] FAIL flush_ack_idle: got %b expected 0", o_bus_req); end
    nChecks++;
    if (dut.u_fifo.o_count !== 3'd0) begin nFails++; $display("[TB] FAIL flush_ack_count: got %0d expected 0", dut.u_fifo.o_count); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    int c0;
    doReset();
    readyS = 1'b0; ackS = 1'b1; fpc = 30'h3FFFFFFF;
    repeat (4) step();
    rstS = 1'b1;
    step();
    rstS = 1'b0;
    nChecks++;
    if (o_valid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", o_valid); end
    nChecks++;
    if (o_bus_req !== 1'b0) begin nFails++; $display("[TB] FAIL mid_reset_req: got %b expected 0", o_bus_req); end
    nChecks++;
    if (o_bus_addr !== 30'h0) begin nFails++; $display("[TB] FAIL mid_reset_addr: got %h expected 0", o_bus_addr); end
    c0 = accCount;
    repeat (2) step();
    nChecks++;
    if (accCount !== c0 + 1) begin nFails++; $display("[TB] FAIL mid_reset_fresh: got %0d expected %0d", accCount - c0, 1); end
  endtask

  task automatic test_bypass();
    doReset();
    readyS = 1'b1; ackS = 1'b0; fpc = 30'h55;
    step();
    useFixed = 1'b1; fixedData = 32'h0000_0013; ackS = 1'b1;
    step();
    useFixed = 1'b0; ackS = 1'b0;
    nChecks++;
    if (sValid !== BYP) begin nFails++; $display("[TB] FAIL bypass_same_cycle_valid: got %b expected %b", sValid, BYP); end
    if (BYP) begin
      nChecks++;
      if (sInstr !== 32'h13) begin nFails++; $display("[TB] FAIL bypass_instr: got %h expected 13", sInstr); end
    end
    nChecks++;
    if (o_valid !== !BYP) begin nFails++; $display("[TB] FAIL bypass_next_valid: got %b expected %b", o_valid, !BYP); end
    if (!BYP) begin
      nChecks++;
      if (o_instr !== 32'h13) begin nFails++; $display("[TB] FAIL queued_instr: got %h expected 13", o_instr); end
    end
    nChecks++;
    if (dut.u_fifo.o_count !== (BYP ? 3'd0 : 3'd1)) begin
      nFails++; $display("[TB] FAIL bypass_count: got %0d expected %0d", dut.u_fifo.o_count, BYP ? 0 : 1);
    end
    repeat (2) step();
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 3000; i++) begin
      rstS   = ($urandom_range(0, 199) == 0);
      flushS = ($urandom_range(0, 19) == 0);
      ackS   = ($urandom_range(0, 2) != 0);
      readyS = $urandom_range(0, 1) == 1;
      tgtS   = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFE : 30'($urandom);
      step();
    end
    rstS = 1'b0; flushS = 1'b0;
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_stream();
    test_full();
    test_flush_drop();
    test_flush_ack();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
